// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   - Default memory window (base byte address and size in bytes)
//   - Access-size encodings as driven on dm_size / mem_access_size
//   - Arbiter FSM state and grant-select types
//   - Read-data zero-extension helper
package mem_pkg;

  localparam logic [31:0] DEFAULT_OFFSET = 32'h8002_0000;
  localparam logic [31:0] DEFAULT_SIZE   = 32'h0010_0000;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StAcc
  } arb_state_e;

  typedef enum logic [0:0] {
    GntIf,
    GntDm
  } grant_e;

  // Memory returns sub-word reads right-justified, but the bits above the access
  // width are whatever was left from an earlier read, so they are always cleared.
  function automatic logic [31:0] zext_rdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] r;
    r = data;
    case (size)
      SZ_BYTE: r = {24'b0, data[7:0]};
      SZ_HALF: r = {16'b0, data[15:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_req_check.sv
// Combinational legality check of one memory request.
//   addr  : request byte address
//   size  : access size encoding (byte/half/word/illegal)
//   err   : 1 if the size is illegal, the address is misaligned, or the access
//           does not lie entirely inside [OFFSET, OFFSET+SIZE)
//   bytes : number of bytes touched by the access (0 for the illegal size)
module mem_req_check
  import mem_pkg::*;
#(
  parameter logic [31:0] OFFSET = DEFAULT_OFFSET,
  parameter logic [31:0] SIZE   = DEFAULT_SIZE
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic        err,
  output logic [2:0]  bytes
);

  logic        bad_size;
  logic        misaligned;
  logic        below;
  logic        past_end;
  logic [32:0] end_rel;

  always_comb begin
    bytes      = 3'd0;
    bad_size   = 1'b0;
    misaligned = 1'b0;
    unique case (size)
      SZ_BYTE: bytes = 3'd1;
      SZ_HALF: begin
        bytes      = 3'd2;
        misaligned = addr[0];
      end
      SZ_WORD: begin
        bytes      = 3'd4;
        misaligned = |addr[1:0];
      end
      SZ_ILLEGAL: bad_size = 1'b1;
    endcase

    below = addr < OFFSET;
    // 33 bits so an access ending exactly at 2^32 cannot wrap back into range.
    end_rel  = {1'b0, addr - OFFSET} + {30'b0, bytes};
    past_end = end_rel > {1'b0, SIZE};

    err = bad_size | misaligned | below | past_end;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-ported, byte-addressed,
// big-endian memory sampled on the negative clock edge.
//   clk, rst          : clock; synchronous active-high reset
//   if_*              : fetch port (always 32-bit reads): req/ready/valid/rdata/err
//   dm_*              : load/store port: req/ready, addr, wdata, write, size,
//                       valid/rdata/err
//   mem_*             : memory controls (address, data_in, write, access_size)
//                       and read data (data_out)
// Each accepted request spends one ACC cycle at the memory; its response is a
// one-cycle valid pulse in the following cycle. Round-robin on ties.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter logic [31:0] OFFSET = DEFAULT_OFFSET,
  parameter logic [31:0] SIZE   = DEFAULT_SIZE
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,

  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic        dm_write,
  input  logic [1:0]  dm_size,
  output logic        dm_ready,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,

  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_write,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_data_out
);

  arb_state_e  state_q, state_d;
  grant_e      last_grant_q;
  grant_e      grant;
  logic        accept;

  // Granted request, muxed ahead of the checker.
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_size;
  logic        sel_write;
  logic        sel_err;
  logic [2:0]  sel_bytes;
  logic        unused_sel_bytes;

  // Context of the access in flight.
  grant_e      acc_grant_q;
  logic        acc_write_q;
  logic        acc_err_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_data_in_q;
  logic [1:0]  mem_access_size_q;

  logic [31:0] rsp_rdata;

  logic        if_valid_q, dm_valid_q;
  logic [31:0] if_rdata_q, dm_rdata_q;
  logic        if_err_q, dm_err_q;

  // Round-robin: on a tie grant whoever was not granted last.
  always_comb begin
    if (if_req && dm_req) begin
      grant = (last_grant_q == GntIf) ? GntDm : GntIf;
    end else if (dm_req) begin
      grant = GntDm;
    end else begin
      grant = GntIf;
    end
  end

  assign accept   = (state_q == StIdle) && !rst && (if_req || dm_req);
  assign if_ready = accept && (grant == GntIf);
  assign dm_ready = accept && (grant == GntDm);

  always_comb begin
    if (grant == GntDm) begin
      sel_addr  = dm_addr;
      sel_wdata = dm_wdata;
      sel_size  = dm_size;
      sel_write = dm_write;
    end else begin
      sel_addr  = if_addr;
      sel_wdata = 32'h0;
      sel_size  = SZ_WORD;
      sel_write = 1'b0;
    end
  end

  mem_req_check #(
    .OFFSET (OFFSET),
    .SIZE   (SIZE)
  ) u_req_check (
    .addr  (sel_addr),
    .size  (sel_size),
    .err   (sel_err),
    .bytes (sel_bytes)
  );

  assign unused_sel_bytes = ^sel_bytes;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StAcc;
      StAcc:  state_d = StIdle;
    endcase
  end

  // Not gated by rst: an access already at the memory completes even if reset
  // arrives during ACC.
  assign mem_write = (state_q == StAcc) && acc_write_q && !acc_err_q;

  assign rsp_rdata = (acc_err_q || acc_write_q) ? 32'h0
                                                : zext_rdata(mem_access_size_q, mem_data_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      last_grant_q      <= GntIf;
      acc_grant_q       <= GntIf;
      acc_write_q       <= 1'b0;
      acc_err_q         <= 1'b0;
      mem_address_q     <= 32'h0;
      mem_data_in_q     <= 32'h0;
      mem_access_size_q <= 2'b00;
      if_valid_q        <= 1'b0;
      if_rdata_q        <= 32'h0;
      if_err_q          <= 1'b0;
      dm_valid_q        <= 1'b0;
      dm_rdata_q        <= 32'h0;
      dm_err_q          <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Responses are single-cycle pulses; cleared unless set below.
      if_valid_q <= 1'b0;
      if_rdata_q <= 32'h0;
      if_err_q   <= 1'b0;
      dm_valid_q <= 1'b0;
      dm_rdata_q <= 32'h0;
      dm_err_q   <= 1'b0;

      if (accept) begin
        last_grant_q      <= grant;
        acc_grant_q       <= grant;
        acc_write_q       <= sel_write;
        acc_err_q         <= sel_err;
        mem_address_q     <= sel_addr;
        mem_data_in_q     <= sel_wdata;
        mem_access_size_q <= sel_size;
      end

      if (state_q == StAcc) begin
        if (acc_grant_q == GntIf) begin
          if_valid_q <= 1'b1;
          if_rdata_q <= rsp_rdata;
          if_err_q   <= acc_err_q;
        end else begin
          dm_valid_q <= 1'b1;
          dm_rdata_q <= rsp_rdata;
          dm_err_q   <= acc_err_q;
        end
      end
    end
  end

  assign mem_address     = mem_address_q;
  assign mem_data_in     = mem_data_in_q;
  assign mem_access_size = mem_access_size_q;

  assign if_valid = if_valid_q;
  assign if_rdata = if_rdata_q;
  assign if_err   = if_err_q;
  assign dm_valid = dm_valid_q;
  assign dm_rdata = dm_rdata_q;
  assign dm_err   = dm_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural big-endian memory that
// acts on the falling edge and leaves stale upper bits on sub-word reads.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam logic [31:0] OFF = 32'h8002_0000;
  localparam logic [31:0] SZ  = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ready, if_valid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_write, dm_ready, dm_valid, dm_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [1:0]  dm_size;
  logic [31:0] mem_address, mem_data_in;
  logic        mem_write;
  logic [1:0]  mem_access_size;
  logic [31:0] mem_data_out = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .OFFSET (OFF),
    .SIZE   (SZ)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_ready        (if_ready),
    .if_valid        (if_valid),
    .if_rdata        (if_rdata),
    .if_err          (if_err),
    .dm_req          (dm_req),
    .dm_addr         (dm_addr),
    .dm_wdata        (dm_wdata),
    .dm_write        (dm_write),
    .dm_size         (dm_size),
    .dm_ready        (dm_ready),
    .dm_valid        (dm_valid),
    .dm_rdata        (dm_rdata),
    .dm_err          (dm_err),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_write       (mem_write),
    .mem_access_size (mem_access_size),
    .mem_data_out    (mem_data_out)
  );

  // Behavioural memory: 4 KiB alias of the window is enough for these tests.
  logic [7:0] mem_bytes [4096] = '{default: 8'h00};

  function automatic logic [11:0] idx(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] r;
    r = a - OFF + k;
    return r[11:0];
  endfunction

  always @(negedge clk) begin
    if (mem_write) begin
      case (mem_access_size)
        SZ_BYTE: mem_bytes[idx(mem_address, 0)] <= mem_data_in[7:0];
        SZ_HALF: begin
          mem_bytes[idx(mem_address, 0)] <= mem_data_in[15:8];
          mem_bytes[idx(mem_address, 1)] <= mem_data_in[7:0];
        end
        default: begin
          mem_bytes[idx(mem_address, 0)] <= mem_data_in[31:24];
          mem_bytes[idx(mem_address, 1)] <= mem_data_in[23:16];
          mem_bytes[idx(mem_address, 2)] <= mem_data_in[15:8];
          mem_bytes[idx(mem_address, 3)] <= mem_data_in[7:0];
        end
      endcase
    end else begin
      case (mem_access_size)
        SZ_BYTE: mem_data_out[7:0] <= mem_bytes[idx(mem_address, 0)];
        SZ_HALF: mem_data_out[15:0] <= {mem_bytes[idx(mem_address, 0)],
                                        mem_bytes[idx(mem_address, 1)]};
        default: mem_data_out <= {mem_bytes[idx(mem_address, 0)], mem_bytes[idx(mem_address, 1)],
                                  mem_bytes[idx(mem_address, 2)], mem_bytes[idx(mem_address, 3)]};
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          dm;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          write;
    logic [1:0]  size;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_wr;
  } vec_t;

  // One transaction on an idle arbiter: ready in cycle N, valid only in N+2.
  task automatic xact(input vec_t v, input string tag);
    int n   = 0;
    bit got = 1'b0;
    int wr  = 0;
    if (v.dm) begin
      dm_req   = 1'b1;
      dm_addr  = v.addr;
      dm_wdata = v.wdata;
      dm_write = v.write;
      dm_size  = v.size;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    while (!got && n < 16) begin
      @(negedge clk);
      got = v.dm ? dm_ready : if_ready;
      n++;
      @(posedge clk);
      #1;
    end
    chk({tag, " accept_cycle"}, 32'(n), 32'd1);
    if_req = 1'b0;
    dm_req = 1'b0;
    if (!got) return;
    @(negedge clk);
    wr += int'(mem_write);
    chk({tag, " valid_n1"}, 32'(v.dm ? dm_valid : if_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    wr += int'(mem_write);
    chk({tag, " valid_n2"}, 32'(v.dm ? dm_valid : if_valid), 32'd1);
    chk({tag, " rdata"}, v.dm ? dm_rdata : if_rdata, v.exp_rdata);
    chk({tag, " err"}, 32'(v.dm ? dm_err : if_err), 32'(v.exp_err));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, " valid_n3"}, 32'(v.dm ? dm_valid : if_valid), 32'd0);
    chk({tag, " wr_pulses"}, 32'(wr), 32'(v.exp_wr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  vec_t vecs [21];

  initial begin
    //          dm    addr            wdata         wr    size        rdata         err   wr#
    vecs[0]  = '{1'b1, 32'h8002_0000, 32'hDEADBEEF, 1'b1, SZ_WORD,    32'h0000_0000, 1'b0, 1};
    vecs[1]  = '{1'b0, 32'h8002_0000, 32'h0,        1'b0, SZ_WORD,    32'hDEADBEEF, 1'b0, 0};
    vecs[2]  = '{1'b1, 32'h8002_0003, 32'h0000_00A5, 1'b1, SZ_BYTE,   32'h0000_0000, 1'b0, 1};
    vecs[3]  = '{1'b1, 32'h8002_0000, 32'h0,        1'b0, SZ_WORD,    32'hDEADBEA5, 1'b0, 0};
    vecs[4]  = '{1'b1, 32'h8002_0000, 32'h11223344, 1'b1, SZ_WORD,    32'h0000_0000, 1'b0, 1};
    vecs[5]  = '{1'b1, 32'h8002_0002, 32'h0,        1'b0, SZ_HALF,    32'h0000_3344, 1'b0, 0};
    vecs[6]  = '{1'b1, 32'h8002_0001, 32'h0,        1'b0, SZ_BYTE,    32'h0000_0022, 1'b0, 0};
    vecs[7]  = '{1'b1, 32'h8002_0006, 32'h0000_ABCD, 1'b1, SZ_HALF,   32'h0000_0000, 1'b0, 1};
    vecs[8]  = '{1'b1, 32'h8002_0004, 32'h0,        1'b0, SZ_WORD,    32'h0000_ABCD, 1'b0, 0};
    vecs[9]  = '{1'b1, 32'h8002_0002, 32'hFFFF_FFFF, 1'b1, SZ_WORD,   32'h0000_0000, 1'b1, 0};
    vecs[10] = '{1'b1, 32'h8001_FFFC, 32'h0,        1'b0, SZ_WORD,    32'h0000_0000, 1'b1, 0};
    vecs[11] = '{1'b1, 32'h8011_FFFE, 32'h0,        1'b0, SZ_WORD,    32'h0000_0000, 1'b1, 0};
    vecs[12] = '{1'b1, 32'h8012_0000, 32'h0,        1'b0, SZ_BYTE,    32'h0000_0000, 1'b1, 0};
    vecs[13] = '{1'b1, 32'h8011_FFFC, 32'h0,        1'b0, SZ_WORD,    32'h0000_0000, 1'b0, 0};
    vecs[14] = '{1'b1, 32'h8002_0000, 32'h0,        1'b0, SZ_ILLEGAL, 32'h0000_0000, 1'b1, 0};
    vecs[15] = '{1'b0, 32'h8002_0002, 32'h0,        1'b0, SZ_WORD,    32'h0000_0000, 1'b1, 0};
    vecs[16] = '{1'b0, 32'h8001_FFFC, 32'h0,        1'b0, SZ_WORD,    32'h0000_0000, 1'b1, 0};
    vecs[17] = '{1'b1, 32'h8002_0000, 32'h0,        1'b0, SZ_WORD,    32'h11223344, 1'b0, 0};
    vecs[18] = '{1'b1, 32'h8002_0010, 32'h55667788, 1'b1, SZ_WORD,    32'h0000_0000, 1'b0, 1};
    vecs[19] = '{1'b1, 32'h8002_0000, 32'h0,        1'b1, SZ_ILLEGAL, 32'h0000_0000, 1'b1, 0};
    vecs[20] = '{1'b1, 32'h8002_0000, 32'h0,        1'b0, SZ_WORD,    32'h11223344, 1'b0, 0};

    rst      = 1'b1;
    if_req   = 1'b0;
    if_addr  = 32'h0;
    dm_req   = 1'b0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;
    dm_write = 1'b0;
    dm_size  = SZ_BYTE;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst if_ready", 32'(if_ready), 32'd0);
    chk("rst dm_ready", 32'(dm_ready), 32'd0);
    chk("rst if_valid", 32'(if_valid), 32'd0);
    chk("rst dm_valid", 32'(dm_valid), 32'd0);
    chk("rst if_err", 32'(if_err), 32'd0);
    chk("rst dm_err", 32'(dm_err), 32'd0);
    chk("rst if_rdata", if_rdata, 32'd0);
    chk("rst dm_rdata", dm_rdata, 32'd0);
    chk("rst mem_write", 32'(mem_write), 32'd0);
    chk("rst mem_address", mem_address, 32'd0);
    chk("rst mem_data_in", mem_data_in, 32'd0);
    chk("rst mem_access_size", 32'(mem_access_size), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      xact(vecs[i], $sformatf("vec%0d", i));
    end

    // Both ports requesting from reset: dm, if, dm, if ...; request held in
    // reset must not be accepted.
    rst     = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h8002_0000;
    dm_req  = 1'b1;
    dm_addr = 32'h8002_0010;
    dm_write = 1'b0;
    dm_size = SZ_WORD;
    @(negedge clk);
    chk("arb rst if_ready", 32'(if_ready), 32'd0);
    chk("arb rst dm_ready", 32'(dm_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("arb c%0d dm_ready", c), 32'(dm_ready), 32'(c % 4 == 0));
      chk($sformatf("arb c%0d if_ready", c), 32'(if_ready), 32'(c % 4 == 2));
      chk($sformatf("arb c%0d dm_valid", c), 32'(dm_valid), 32'(c % 4 == 2));
      chk($sformatf("arb c%0d if_valid", c), 32'(if_valid), 32'(c % 4 == 0 && c > 0));
      if (dm_valid) chk($sformatf("arb c%0d dm_rdata", c), dm_rdata, 32'h55667788);
      if (if_valid) chk($sformatf("arb c%0d if_rdata", c), if_rdata, 32'h11223344);
      @(posedge clk);
      #1;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset during ACC of a store: write still lands, response is dropped.
    begin
      int n   = 0;
      bit got = 1'b0;
      dm_req   = 1'b1;
      dm_addr  = 32'h8002_0008;
      dm_wdata = 32'hCAFEF00D;
      dm_write = 1'b1;
      dm_size  = SZ_WORD;
      while (!got && n < 16) begin
        @(negedge clk);
        got = dm_ready;
        n++;
        @(posedge clk);
        #1;
      end
      chk("rstacc accept_cycle", 32'(n), 32'd1);
      rst    = 1'b1;
      dm_req = 1'b0;
      @(negedge clk);
      chk("rstacc mem_write_in_acc", 32'(mem_write), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstacc dm_valid", 32'(dm_valid), 32'd0);
      chk("rstacc if_valid", 32'(if_valid), 32'd0);
      chk("rstacc dm_err", 32'(dm_err), 32'd0);
      chk("rstacc dm_rdata", dm_rdata, 32'd0);
      chk("rstacc mem_write", 32'(mem_write), 32'd0);
      chk("rstacc mem_address", mem_address, 32'd0);
      chk("rstacc mem_data_in", mem_data_in, 32'd0);
      chk("rstacc mem_access_size", 32'(mem_access_size), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rstacc dm_valid_later", 32'(dm_valid), 32'd0);
      @(posedge clk);
      #1;
      dm_write = 1'b0;
      xact('{1'b1, 32'h8002_0008, 32'h0, 1'b0, SZ_WORD, 32'hCAFEF00D, 1'b0, 0}, "rstacc readback");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
